seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex seven-segment scan driver with double-buffered display data
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   points,
    input  logic [DIGITS-1:0]   blink_en,
    input  logic                blank_lz,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   dig_sel,
    output logic                frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_shd_val;
    logic [DIGITS-1:0]   r_shd_pts;
    logic [DIGITS-1:0]   r_shd_blk;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_act_val;
    logic [DIGITS-1:0]   r_act_pts;
    logic [DIGITS-1:0]   r_act_blk;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_boundary;
    logic                w_run_zero;
    logic [DIGITS-1:0]   w_lz_mask;
    logic [3:0]          w_cur_nib;
    logic                w_cur_pt;
    logic                w_cur_blk;
    logic                w_cur_lz;
    logic [7:0]          w_seg_nxt;
    logic [DIGITS-1:0]   w_dig_nxt;

    // Active-high a..g segment pattern for one hex nibble
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h67;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_idx == IDX_LAST);

    // Slot prescaler, digit index and the frame boundary pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Shadow capture on load; shadow moves to active only at a frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shd_val <= '0;
            r_shd_pts <= '0;
            r_shd_blk <= '0;
            r_pending <= 1'b0;
            r_act_val <= '0;
            r_act_pts <= '0;
            r_act_blk <= '0;
        end else begin
            if (load) begin
                r_shd_val <= value;
                r_shd_pts <= points;
                r_shd_blk <= blink_en;
            end
            if (w_boundary) begin
                if (load) begin
                    r_act_val <= value;
                    r_act_pts <= points;
                    r_act_blk <= blink_en;
                end else if (r_pending) begin
                    r_act_val <= r_shd_val;
                    r_act_pts <= r_shd_pts;
                    r_act_blk <= r_shd_blk;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_boundary) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i blanks when it and every digit above it are zero
    always_comb begin
        w_run_zero = 1'b1;
        w_lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run_zero = w_run_zero & (r_act_val[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lz_mask[i] = blank_lz & w_run_zero;
            end
        end
    end

    // Select the active data belonging to the digit being scanned
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_pt  = 1'b0;
        w_cur_blk = 1'b0;
        w_cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_nib = r_act_val[4*i +: 4];
                w_cur_pt  = r_act_pts[i];
                w_cur_blk = r_act_blk[i];
                w_cur_lz  = w_lz_mask[i];
            end
        end
    end

    // Pin values for the current slot; all dark during the guard window
    always_comb begin
        w_seg_nxt = 8'hFF;
        w_dig_nxt = '1;
        if (r_presc >= GUARD_END) begin
            w_dig_nxt = ~(DIGITS'(1) << r_idx);
            if (!(r_phase && w_cur_blk)) begin
                w_seg_nxt = ~{w_cur_pt, (w_cur_lz ? 7'h00 : glyph(w_cur_nib))};
            end
        end
    end

    // Register the pins so they change cleanly one cycle after the scan state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg     <= 8'hFF;
            r_dig_sel <= '1;
        end else begin
            r_seg     <= w_seg_nxt;
            r_dig_sel <= w_dig_nxt;
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  points;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb_q[$];
    logic [3:0]  prev_dig = 4'hF;
    logic [11:0] cur_exp;
    logic        have_cur = 1'b0;

    seg7_scan_driver #(
        .DIGITS(4), .CLK_DIV(4), .GUARD(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .points(points), .blink_en(blink_en), .blank_lz(blank_lz),
        .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        sb_q.push_back({4'hE, s0});
        sb_q.push_back({4'hD, s1});
        sb_q.push_back({4'hB, s2});
        sb_q.push_back({4'h7, s3});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
        value    = v;
        points   = p;
        blink_en = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        value    = 16'hxxxx;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        if (frame_done !== 1'b1) check("frame_timeout", {31'b0, frame_done}, 32'd1);
    endtask

    // Monitor: each slot start pops one expected {dig_sel, seg}; every lit cycle of that slot is compared
    always @(negedge clk) begin
        if (dig_sel != 4'hF) begin
            if (prev_dig == 4'hF) begin
                if (sb_q.size() > 0) begin
                    cur_exp  = sb_q.pop_front();
                    have_cur = 1'b1;
                end else begin
                    have_cur = 1'b0;
                end
            end
            if (have_cur) check("slot", {20'b0, dig_sel, seg}, {20'b0, cur_exp});
        end
        prev_dig = dig_sel;
    end

    initial begin
        logic [7:0] blink_d0[6];
        logic [3:0] exp_dig;
        int j;
        int n;
        blink_d0 = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF};

        rst_n = 1'b0; load = 1'b0; value = 16'h0; points = 4'h0;
        blink_en = 4'h0; blank_lz = 1'b0;

        // reset held three cycles, then free-running scan of blank-free zeros
        repeat (3) begin
            @(negedge clk);
            check("rst_seg", {24'b0, seg}, 32'hFF);
            check("rst_dig", {28'b0, dig_sel}, 32'hF);
            check("rst_fd", {31'b0, frame_done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            j = k - 1;
            exp_dig = ((j % 4) == 0) ? 4'hF : ~(4'b0001 << ((j / 4) % 4));
            check("scan_dig", {28'b0, dig_sel}, {28'b0, exp_dig});
            check("scan_seg", {24'b0, seg}, (exp_dig == 4'hF) ? 32'hFF : 32'hC0);
            check("scan_fd", {31'b0, frame_done}, ((k % 16) == 0) ? 32'd1 : 32'd0);
        end

        // glyph sweep over all sixteen hex digits
        do_load(16'h3210, 4'h0, 4'h0); wait_frame(); push_frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        do_load(16'h7654, 4'h0, 4'h0); wait_frame(); push_frame(8'h99, 8'h92, 8'h82, 8'hF8);
        do_load(16'hBA98, 4'h0, 4'h0); wait_frame(); push_frame(8'h80, 8'h98, 8'h88, 8'h83);
        do_load(16'hFEDC, 4'h0, 4'h0); wait_frame(); push_frame(8'hC6, 8'hA1, 8'h86, 8'h8E);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b1000, 4'h0); wait_frame(); push_frame(8'hC0, 8'h92, 8'hFF, 8'h7F);
        do_load(16'h0000, 4'h0, 4'h0);    wait_frame(); push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        wait_frame();
        blank_lz = 1'b0;

        // double buffering: two loads mid-frame, old value holds, last load wins
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'h0, 4'h0);
        @(negedge clk);
        do_load(16'h2222, 4'h0, 4'h0);
        wait_frame();
        push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);

        // load exactly on the boundary cycle goes straight to the next frame
        repeat (15) @(negedge clk);
        check("pre_bnd_fd", {31'b0, frame_done}, 32'd0);
        do_load(16'h4444, 4'h0, 4'h0);
        check("bnd_fd", {31'b0, frame_done}, 32'd1);
        push_frame(8'h99, 8'h99, 8'h99, 8'h99);

        // reset during the digit2 slot
        wait_frame();
        repeat (10) @(negedge clk);
        check("pre_rst_dig", {28'b0, dig_sel}, 32'hB);
        check("pre_rst_seg", {24'b0, seg}, 32'h99);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_seg", {24'b0, seg}, 32'hFF);
        check("mid_rst_dig", {28'b0, dig_sel}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // blink on digit0 from a fresh phase
        do_load(16'h0008, 4'h0, 4'b0001);
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            push_frame(blink_d0[f], 8'hC0, 8'hC0, 8'hC0);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
